// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: pipeline control in, instruction ROM bus, and the IF/ID register outputs.
interface inst_fetch_if;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall, flush, redirect, redirect_pc, rom_inst,
        output rom_addr, id_inst, id_pc, id_pc4, id_valid, fetch_cnt
    );

    modport slave (
        output stall, flush, redirect, redirect_pc, rom_inst,
        input  rom_addr, id_inst, id_pc, id_pc4, id_valid, fetch_cnt
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, early absolute-jump decode and the IF/ID pipeline register.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [5:0]  JUMP_OP  = 6'b010010
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] idpc_q, idpc_d;
    logic [31:0] idpc4_q, idpc4_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_plus4;
    logic        is_jump;

    assign pc_plus4 = pc_q + 32'd4;
    assign is_jump  = (bus.rom_inst[31:26] == JUMP_OP);

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        idpc_d  = idpc_q;
        idpc4_d = idpc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (bus.redirect) begin
            // Redirect wins over stall and flush; bubble keeps the old id_pc/id_pc4.
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            inst_d  = 32'd0;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            if (bus.flush) begin
                inst_d  = 32'd0;
                valid_d = 1'b0;
            end
        end else begin
            pc_d = is_jump ? {pc_q[31:28], bus.rom_inst[25:0], 2'b00} : pc_plus4;
            if (bus.flush) begin
                inst_d  = 32'd0;
                valid_d = 1'b0;
            end else begin
                inst_d  = bus.rom_inst;
                idpc_d  = pc_q;
                idpc4_d = pc_plus4;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            idpc_q  <= 32'd0;
            idpc4_q <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rom_addr  = pc_q;
    assign bus.id_inst   = inst_q;
    assign bus.id_pc     = idpc_q;
    assign bus.id_pc4    = idpc4_q;
    assign bus.id_valid  = valid_q;
    assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a small combinational ROM model.
module tb_inst_fetch;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [31:0] rom [64];

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC (32'h00000000),
        .JUMP_OP  (6'b010010)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.rom_inst = rom[bus.rom_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                          input logic [31:0] pc, input logic [31:0] pc4, input logic valid,
                          input logic [31:0] cnt);
        chk({tag, ".rom_addr"}, bus.rom_addr, addr);
        chk({tag, ".id_inst"}, bus.id_inst, inst);
        chk({tag, ".id_pc"}, bus.id_pc, pc);
        chk({tag, ".id_pc4"}, bus.id_pc4, pc4);
        chk({tag, ".id_valid"}, {31'd0, bus.id_valid}, {31'd0, valid});
        chk({tag, ".fetch_cnt"}, bus.fetch_cnt, cnt);
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        #2;
        chk_id("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        tick();
        chk_id("seq0", 32'h4, 32'h40001021, 32'h0, 32'h4, 1'b1, 32'd1);
        tick();
        chk_id("seq1", 32'h8, 32'h3C000C42, 32'h4, 32'h8, 1'b1, 32'd2);
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_id("stall", 32'h8, 32'h3C000C42, 32'h4, 32'h8, 1'b1, 32'd2);
        end
        bus.flush = 1'b1;
        tick();
        chk_id("stall_flush", 32'h8, 32'h0, 32'h4, 32'h8, 1'b0, 32'd2);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        tick();
        chk_id("resume", 32'hC, 32'h12345678, 32'h8, 32'hC, 1'b1, 32'd3);
    endtask

    task automatic test_early_jump();
        tick();
        chk_id("jump", 32'h4, 32'h48000001, 32'hC, 32'h10, 1'b1, 32'd4);
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        tick();
        chk_id("flush", 32'h8, 32'h0, 32'hC, 32'h10, 1'b0, 32'd4);
        bus.flush = 1'b0;
    endtask

    task automatic test_redirect_stall();
        bus.stall       = 1'b1;
        bus.flush       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h00000023;
        tick();
        chk_id("redir", 32'h20, 32'h0, 32'hC, 32'h10, 1'b0, 32'd4);
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.redirect = 1'b0;
        tick();
        chk_id("redir_next", 32'h24, 32'h11110000, 32'h20, 32'h24, 1'b1, 32'd5);
    endtask

    task automatic test_wrap();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFFFFFE;
        tick();
        chk("wrap_pc", bus.rom_addr, 32'hFFFFFFFC);
        bus.redirect = 1'b0;
        tick();
        // All-zero word must still be a valid fetch.
        chk_id("wrap", 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'd6);
    endtask

    task automatic test_async_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h00000010;
        tick();
        bus.redirect = 1'b0;
        tick();
        chk_id("pre_rst", 32'h14, 32'hAABBCCDD, 32'h10, 32'h14, 1'b1, 32'd7);
        bus.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_id("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        bus.stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_id("post_rst", 32'h4, 32'h40001021, 32'h0, 32'h4, 1'b1, 32'd1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        rom[0] = 32'h40001021;
        rom[1] = 32'h3C000C42;
        rom[2] = 32'h12345678;
        rom[3] = 32'h48000001;
        rom[4] = 32'hAABBCCDD;
        rom[8] = 32'h11110000;

        test_reset();
        test_sequential();
        test_stall();
        test_early_jump();
        test_flush();
        test_redirect_stall();
        test_wrap();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
